ysyx_2022040010_regfile: RTL and testbench
==========================================

# ysyx_2022040010_regfile

Architectural integer register file, 32 × 64-bit, sitting at the receiving end of the write-back bus. It applies writes from `wb_to_rf_bus`, serves two combinational decode read ports with same-cycle write bypass, and serves one unbypassed debug/difftest read port. It also keeps a per-register pending-write scoreboard so decode can detect RAW hazards and stall.

## Interface
Parameters:
- `XLEN`, 64: data width.
- `NREG`, 32: register count; the address width is 5.
- `SB_W`, 2: width of the per-register pending counter; the maximum count is 3.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wb_to_rf_bus`  in  70 (`BP_TO_RF_BUS`)  packed {`rf_we`[69], `rf_waddr`[68:64], `rf_wdata`[63:0]}.
- `raddr1`, `raddr2`  in  5  decode read addresses.
- `rdata1`, `rdata2`  out  64  decode read data, bypassed.
- `issue_we`  in  1  decode issues an instruction that will write `issue_rd`.
- `issue_rd`  in  5  destination of the issued instruction.
- `flush`  in  1  pipeline flush; clears the scoreboard.
- `busy1`, `busy2`  out  1  source `raddr1`/`raddr2` has a pending write not obtainable this cycle.
- `dbg_raddr`  in  5  debug read address.
- `dbg_rdata`  out  64  array contents, no bypass.
- `sb_err`  out  1  sticky scoreboard under/overflow flag.

## Operation
- **Write:** at the clock edge, if `rf_we` and `rf_waddr != 0`, then `regs[rf_waddr] <= rf_wdata`. A write to x0 is dropped.
- **Read ports 1 and 2:**
  - If `raddrN == 0`, return 0.
  - Otherwise, if `rf_we && rf_waddr == raddrN`, return `rf_wdata` (bypass).
  - Otherwise return `regs[raddrN]`.
- **Debug port:** returns `regs[dbg_raddr]`, with x0 reading 0. It does not bypass, so difftest sees committed state only.
- **Scoreboard:** one `SB_W`-bit counter `cnt[r]` per register; x0 is never tracked.
  - `inc = issue_we && issue_rd == r && r != 0`.
  - `dec = rf_we && rf_waddr == r && r != 0`.
  - If `inc` and not `dec`: `cnt + 1`.
  - If `dec` and not `inc`: `cnt - 1`.
  - If both: unchanged.
  - Increment at 3 saturates at 3 and sets `sb_err`. Decrement at 0 stays at 0 and sets `sb_err`.
- **busyN:**
  - Is 1 when `raddrN != 0` and `cnt[raddrN] != 0`.
  - Exception: the term is masked to 0 when `cnt[raddrN] == 1` and a write to `raddrN` is on the bus this cycle, because the bypass supplies the data.
- **flush:** all counters go to 0 next edge. A concurrent write still updates the array. Concurrent `issue_we` is ignored. `sb_err` is not cleared.
- **Reset:** `rst` high at an edge clears all 31 registers, all counters, and `sb_err`. A write or issue in the same cycle is discarded. Reset mid-stream leaves no pending state.

## Timing
- Reads on `rdata1`, `rdata2`, `dbg_rdata`, `busy1`, `busy2` are combinational, 0-cycle latency.
- A write is visible on the bypassed ports in the same cycle it is presented, and on `dbg_rdata` from the next cycle.
- A counter update takes effect on `busy` in the cycle after the issue/write edge.
- Outputs after reset: `rdata*` = 0 and `dbg_rdata` = 0 (for any address until written), `busy*` = 0, `sb_err` = 0.
- The producer holds `wb_to_rf_bus` stable for the whole cycle; each cycle is an independent single write, with no handshake.

## Structure
- Shared in `defines.v`:
  - `BP_TO_RF_BUS`/`BP_TO_RF_WD` (70).
  - `RegAddrBus` (4:0), `RegBus` (63:0).
  - A `SB_CNT_W` constant (2).
- Sub-module: `ysyx_2022040010_scoreboard`. It takes the counters, issue/write/flush inputs, and outputs busy vector bits plus `sb_err`. The top module holds the array, the bypass muxes, and the debug port.

## Test plan
- **Reset then read:** reset, read x5 on `raddr1` -> `rdata1` = 0, `busy1` = 0, `sb_err` = 0.
- **Write with bypass:**
  - Bus {1, 5, 0xDEAD_BEEF_0000_0001}; `raddr1` = 5 in the same cycle -> `rdata1` = 0xDEAD_BEEF_0000_0001 while `dbg_rdata(5)` is still 0.
  - Next cycle -> `dbg_rdata` = 0xDEAD_BEEF_0000_0001.
- **x0 writes:** write 0xFFFF to x0 -> `rdata1(0)`, `dbg_rdata(0)` = 0 in both cycles; no counter change.
- **Scoreboard lifecycle:**
  - Issue rd = 7 twice on consecutive cycles -> `busy1(7)` = 1.
  - First write to x7 -> `busy1` stays 1.
  - Second write to x7 -> `busy1` = 0 in the write cycle (bypass case).
  - Next cycle `cnt` = 0.
- **Simultaneous issue and write:** issue rd = 3 and write x3 in the same cycle, with `cnt` = 1 -> `cnt` stays 1, `busy(3)` = 1 afterwards.
- **Flush, reset and overflow:**
  - Flush with rd = 9 pending plus a concurrent write of 0x42 to x4 -> `busy(9)` = 0 next cycle, x4 = 0x42.
  - Four issues to x2 without writes -> `sb_err` = 1, sticky until `rst`.

Source files
------------

// File: rtl/ysyx_2022040010_regfile_pkg.sv
// Shared widths and the write-back bus layout for the integer register file.
// pack_wb() builds a bus word in the documented field order.
package ysyx_2022040010_regfile_pkg;

    localparam int XLEN_W      = 64;
    localparam int REG_ADDR_W  = 5;
    localparam int NREG_N      = 32;
    localparam int SB_CNT_W    = 2;
    localparam int BP_TO_RF_WD = 1 + REG_ADDR_W + XLEN_W;

    // Bus layout, MSB first: {rf_we, rf_waddr, rf_wdata}.
    function automatic logic [BP_TO_RF_WD-1:0] pack_wb(
        input logic                  we,
        input logic [REG_ADDR_W-1:0] waddr,
        input logic [XLEN_W-1:0]     wdata
    );
        return {we, waddr, wdata};
    endfunction

endpackage

// File: rtl/ysyx_2022040010_scoreboard.sv
// Per-register pending-write counters used by decode to detect RAW hazards.
// x0 is never tracked; over/underflow saturates and raises a sticky error.
module ysyx_2022040010_scoreboard
    import ysyx_2022040010_regfile_pkg::*;
#(
    parameter int NREG = NREG_N,
    parameter int SB_W = SB_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_we,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  wr_we,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  sb_err
);

    localparam logic [SB_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][SB_W-1:0]       r_cnt;
    logic                            r_err;
    logic [NREG-1:0]                 w_inc;
    logic [NREG-1:0]                 w_dec;
    logic [NREG-1:0]                 w_full;
    logic [NREG-1:0]                 w_empty;
    logic [1:0][REG_ADDR_W-1:0]      w_ra;
    logic [1:0][SB_W-1:0]            w_ra_cnt;
    logic [1:0]                      w_busy;
    logic                            w_err_evt;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                assign w_inc[gi] = 1'b0;
                assign w_dec[gi] = 1'b0;
            end else begin : g_xn
                assign w_inc[gi] = issue_we && (issue_rd == REG_ADDR_W'(gi));
                assign w_dec[gi] = wr_we && (wr_addr == REG_ADDR_W'(gi));
            end
            assign w_full[gi]  = (r_cnt[gi] == CNT_MAX);
            assign w_empty[gi] = (r_cnt[gi] == '0);
        end
    endgenerate

    assign w_err_evt = (|(w_inc & ~w_dec & w_full)) | (|(w_dec & ~w_inc & w_empty));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i] && !w_full[i]) begin
                    r_cnt[i] <= r_cnt[i] + SB_W'(1);
                end else if (w_dec[i] && !w_inc[i] && !w_empty[i]) begin
                    r_cnt[i] <= r_cnt[i] - SB_W'(1);
                end
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_ra[0] = raddr1;
    assign w_ra[1] = raddr2;

    // A last outstanding write that is on the bus now is covered by the bypass.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign w_ra_cnt[gi] = r_cnt[w_ra[gi]];
            assign w_busy[gi]   = (w_ra[gi] != '0) && (w_ra_cnt[gi] != '0) &&
                                  !((w_ra_cnt[gi] == SB_W'(1)) && wr_we && (wr_addr == w_ra[gi]));
        end
    endgenerate

    assign busy1  = w_busy[0];
    assign busy2  = w_busy[1];
    assign sb_err = r_err;

endmodule

// File: rtl/ysyx_2022040010_regfile.sv
// 32 x 64-bit architectural register file: bypassed decode reads, committed-only
// debug read, and a pending-write scoreboard for hazard detection.
module ysyx_2022040010_regfile
    import ysyx_2022040010_regfile_pkg::*;
#(
    parameter int XLEN = XLEN_W,
    parameter int NREG = NREG_N,
    parameter int SB_W = SB_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [XLEN+REG_ADDR_W:0]     wb_to_rf_bus,
    input  logic [REG_ADDR_W-1:0]        raddr1,
    input  logic [REG_ADDR_W-1:0]        raddr2,
    output logic [XLEN-1:0]              rdata1,
    output logic [XLEN-1:0]              rdata2,
    input  logic                         issue_we,
    input  logic [REG_ADDR_W-1:0]        issue_rd,
    input  logic                         flush,
    output logic                         busy1,
    output logic                         busy2,
    input  logic [REG_ADDR_W-1:0]        dbg_raddr,
    output logic [XLEN-1:0]              dbg_rdata,
    output logic                         sb_err
);

    logic                         w_we;
    logic [REG_ADDR_W-1:0]        w_waddr;
    logic [XLEN-1:0]              w_wdata;
    logic [XLEN-1:0]              r_regs [NREG];
    logic [1:0][REG_ADDR_W-1:0]   w_raddr;
    logic [1:0][XLEN-1:0]         w_rdata;

    assign {w_we, w_waddr, w_wdata} = wb_to_rf_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we && (w_waddr != '0)) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign w_rdata[gi] = (w_raddr[gi] == '0)                    ? '0      :
                                 (w_we && (w_waddr == w_raddr[gi]))      ? w_wdata :
                                                                           r_regs[w_raddr[gi]];
        end
    endgenerate

    assign rdata1 = w_rdata[0];
    assign rdata2 = w_rdata[1];

    // Difftest must see committed state only, so no bypass here.
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : r_regs[dbg_raddr];

    ysyx_2022040010_scoreboard #(
        .NREG (NREG),
        .SB_W (SB_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .issue_we (issue_we),
        .issue_rd (issue_rd),
        .wr_we    (w_we),
        .wr_addr  (w_waddr),
        .flush    (flush),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .busy1    (busy1),
        .busy2    (busy2),
        .sb_err   (sb_err)
    );

endmodule

// File: tb/tb_ysyx_2022040010_regfile.sv
// Scoreboard-style bench: stimulus pushes model predictions, a negedge monitor
// pops and compares them against the DUT outputs of the same cycle.
module tb_ysyx_2022040010_regfile;
    import ysyx_2022040010_regfile_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [BP_TO_RF_WD-1:0]  wb_to_rf_bus;
    logic [4:0]              raddr1, raddr2, issue_rd, dbg_raddr;
    logic [63:0]             rdata1, rdata2, dbg_rdata;
    logic                    issue_we, flush, busy1, busy2, sb_err;

    always #5 clk = ~clk;

    ysyx_2022040010_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (wb_to_rf_bus),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .issue_we     (issue_we),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .busy1        (busy1),
        .busy2        (busy2),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata),
        .sb_err       (sb_err)
    );

    typedef struct {
        string       tag;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] dbg;
        logic        b1;
        logic        b2;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;

    // Reference model: architectural contents, pending-write counts, error flag.
    logic [63:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err;

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] a, input bit we,
                                           input logic [4:0] wa, input logic [63:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input bit we, input logic [4:0] wa);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (m_cnt[a] == 1 && we && wa == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge(input bit r, input bit we, input logic [4:0] wa,
                                       input logic [63:0] wd, input bit iwe,
                                       input logic [4:0] rd, input bit fl);
        if (r) begin
            model_reset();
            return;
        end
        if (we && wa != 0) m_regs[wa] = wd;
        if (fl) begin
            for (int k = 0; k < 32; k++) m_cnt[k] = 0;
            return;
        end
        for (int k = 1; k < 32; k++) begin
            bit inc = iwe && (rd == k);
            bit dec = we && (wa == k);
            if (inc && !dec) begin
                if (m_cnt[k] == 3) m_err = 1'b1;
                else m_cnt[k]++;
            end else if (dec && !inc) begin
                if (m_cnt[k] == 0) m_err = 1'b1;
                else m_cnt[k]--;
            end
        end
    endfunction

    task automatic chk(input string tag, input string f, input logic [63:0] got,
                       input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s.%s got=%h want=%h", tag, f, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "rdata1", rdata1, e.r1);
            chk(e.tag, "rdata2", rdata2, e.r2);
            chk(e.tag, "dbg_rdata", dbg_rdata, e.dbg);
            chk(e.tag, "busy1", 64'(busy1), 64'(e.b1));
            chk(e.tag, "busy2", 64'(busy2), 64'(e.b2));
            chk(e.tag, "sb_err", 64'(sb_err), 64'(e.err));
            $display("txn %-12s r1=%0d r2=%0d dbg=%0d busy=%b%b err=%b", e.tag,
                     raddr1, raddr2, dbg_raddr, busy1, busy2, sb_err);
        end
    end

    // One cycle: drive inputs, predict outputs, advance the model at the edge.
    task automatic step(input string tag, input bit r, input bit we, input logic [4:0] wa,
                        input logic [63:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] da, input bit iwe, input logic [4:0] rd,
                        input bit fl);
        exp_t e;
        rst          = r;
        wb_to_rf_bus = pack_wb(we, wa, wd);
        raddr1       = a1;
        raddr2       = a2;
        dbg_raddr    = da;
        issue_we     = iwe;
        issue_rd     = rd;
        flush        = fl;
        e.tag = tag;
        e.r1  = m_read(a1, we, wa, wd);
        e.r2  = m_read(a2, we, wa, wd);
        e.dbg = m_regs[da];
        e.b1  = m_busy(a1, we, wa);
        e.b2  = m_busy(a2, we, wa);
        e.err = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(r, we, wa, wd, iwe, rd, fl);
        #1;
    endtask

    localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

    initial begin
        rst = 1'b1; wb_to_rf_bus = '0; raddr1 = '0; raddr2 = '0; dbg_raddr = '0;
        issue_we = 1'b0; issue_rd = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        //    tag           rst we wa  wd      a1 a2 dbg iwe rd fl
        step("reset_read",  0, 0, 5,  0,      5, 0, 5,  1,  5, 0);
        step("bypass",      0, 1, 5,  DB,     5, 0, 5,  0,  0, 0);
        step("dbg_after",   0, 0, 0,  0,      5, 5, 5,  0,  0, 0);
        step("x0_write",    0, 1, 0,  64'hFFFF, 0, 0, 0, 0, 0, 0);
        step("x0_after",    0, 0, 0,  0,      0, 0, 0,  0,  0, 0);
        step("iss7_a",      0, 0, 0,  0,      7, 7, 7,  1,  7, 0);
        step("iss7_b",      0, 0, 0,  0,      7, 7, 7,  1,  7, 0);
        step("busy7",       0, 0, 0,  0,      7, 0, 7,  0,  0, 0);
        step("wr7_first",   0, 1, 7,  64'h11, 7, 0, 7,  0,  0, 0);
        step("wr7_second",  0, 1, 7,  64'h22, 7, 7, 7,  0,  0, 0);
        step("idle7",       0, 0, 0,  0,      7, 7, 7,  0,  0, 0);
        step("iss3",        0, 0, 0,  0,      0, 3, 3,  1,  3, 0);
        step("iss_wr3",     0, 1, 3,  64'h33, 0, 3, 3,  1,  3, 0);
        step("busy3",       0, 0, 0,  0,      3, 3, 3,  0,  0, 0);
        step("wr3",         0, 1, 3,  64'h34, 3, 3, 3,  0,  0, 0);
        step("iss9",        0, 0, 0,  0,      9, 4, 4,  1,  9, 0);
        step("flush",       0, 1, 4,  64'h42, 9, 4, 4,  1,  9, 1);
        step("post_flush",  0, 0, 0,  0,      9, 4, 4,  0,  0, 0);
        for (int k = 0; k < 4; k++)
            step("ovf2",    0, 0, 0,  0,      2, 0, 2,  1,  2, 0);
        step("err_sticky",  0, 0, 0,  0,      2, 0, 0,  0,  0, 1);
        step("err_hold",    0, 0, 0,  0,      2, 4, 4,  0,  0, 0);
        step("reset_mid",   1, 1, 6,  64'h66, 2, 6, 6,  1,  6, 0);
        step("post_reset",  0, 0, 0,  0,      2, 6, 4,  0,  0, 0);

        for (int n = 0; n < 600; n++) begin
            bit          r   = ($urandom_range(0, 99) == 0);
            bit          we  = $urandom_range(0, 1);
            logic [4:0]  wa  = 5'($urandom_range(0, 7));
            logic [63:0] wd  = {$urandom, $urandom};
            bit          iwe = ($urandom_range(0, 2) == 0);
            logic [4:0]  rd  = 5'($urandom_range(0, 7));
            bit          fl  = ($urandom_range(0, 39) == 0);
            logic [4:0]  a1  = (n % 5 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            logic [4:0]  a2  = 5'($urandom_range(0, 7));
            logic [4:0]  da  = 5'($urandom_range(0, 7));
            step("rand", r, we, wa, wd, a1, a2, da, iwe, rd, fl);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain got=%0d want=0 pending predictions", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
